// File: rtl/prog_clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : prog_clk_div
//  Purpose  : Programmable clock divider. Emits a one-cycle tick once every D
//             enabled cycles. A new divisor is staged in a pending register and
//             takes effect only at a period boundary (or at once while idle).
//             Optional square-wave output, compiled in by defining the macro
//             PROG_CLK_DIV_SQUARE_EN; without it sq_out is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_clk_div #(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 10000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] div_val,
   input  logic             div_load,
   output logic             div_ack,
   output logic             pending,
   output logic             tick,
   output logic             sq_out
);

   localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_pend_val;
   logic             r_pending;
   logic             r_tick;
   logic             r_ack;

   logic [WIDTH-1:0] w_load_val;
   logic             w_wrap;

   // A zero divisor is meaningless, so it is promoted to 1 on capture.
   assign w_load_val = (div_val == '0) ? c_one : div_val;
   // Last cycle of the current period; only counts while enabled.
   assign w_wrap     = en && (r_cnt == (r_div - c_one));

   // Counter, active divisor and pending divisor bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_div      <= c_default_div;
         r_pend_val <= '0;
         r_pending  <= 1'b0;
      end else if (en) begin
         if (w_wrap) begin
            r_cnt <= '0;
            // A load landing on the boundary applies directly, overriding
            // anything already staged.
            if (div_load) begin
               r_div     <= w_load_val;
               r_pending <= 1'b0;
            end else if (r_pending) begin
               r_div     <= r_pend_val;
               r_pending <= 1'b0;
            end
         end else begin
            r_cnt <= r_cnt + c_one;
            if (div_load) begin
               r_pend_val <= w_load_val;
               r_pending  <= 1'b1;
            end
         end
      end else begin
         // While idle there is no period to protect: apply the staged
         // divisor immediately and restart the count.
         if (r_pending) begin
            r_div <= r_pend_val;
            r_cnt <= '0;
         end
         if (div_load) begin
            r_pend_val <= w_load_val;
         end
         r_pending <= div_load;
      end
   end

   // Registered tick at the start of each period and load acknowledge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick <= 1'b0;
         r_ack  <= 1'b0;
      end else begin
         r_tick <= en && (r_cnt == '0);
         r_ack  <= div_load;
      end
   end

   assign tick    = r_tick;
   assign div_ack = r_ack;
   assign pending = r_pending;

`ifdef PROG_CLK_DIV_SQUARE_EN
   logic [WIDTH:0] w_half;
   logic           r_sq;

   // High for the first ceil(D/2) counts; extra bit avoids overflow of D+1.
   assign w_half = ({1'b0, r_div} + (WIDTH+1)'(1)) >> 1;

   // Square wave, frozen while the counter is disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sq <= 1'b0;
      end else if (en) begin
         r_sq <= ({1'b0, r_cnt} < w_half);
      end
   end

   assign sq_out = r_sq;
`else
   assign sq_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_clk_div
//  Purpose  : Self-checking bench for prog_clk_div. Stimulus updates a
//             period-based reference model and queues the expected outputs;
//             a negedge monitor pops and compares them against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_clk_div;

   localparam int WIDTH       = 16;
   localparam int DEFAULT_DIV = 10000;
`ifdef PROG_CLK_DIV_SQUARE_EN
   localparam bit SQ_ON = 1'b1;
`else
   localparam bit SQ_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic [WIDTH-1:0] div_val = '0;
   logic             div_load = 1'b0;
   logic             div_ack;
   logic             pending;
   logic             tick;
   logic             sq_out;

   prog_clk_div #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .div_val  (div_val),
      .div_load (div_load),
      .div_ack  (div_ack),
      .pending  (pending),
      .tick     (tick),
      .sq_out   (sq_out)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit tick;
      bit ack;
      bit pend;
      bit sq;
   } exp_t;

   exp_t exp_q[$];
   int   tick_log[$];
   bit   sq_log[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int pend_act = 0;
   int pend_exp = 0;
   int ack_act  = 0;
   bit track_sq = 1'b0;
   bit no_repeat = 1'b0;
   bit prev_tick = 1'b0;

   // Reference model: a period of length period_len, current position pos
   // within it, and an optional queued length waiting for the period end.
   int period_len = DEFAULT_DIV;
   int pos        = 0;
   int queued_len = 0;
   bit queued     = 1'b0;
   bit m_tick     = 1'b0;
   bit m_ack      = 1'b0;
   bit m_sq       = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
      end
   endtask

   task automatic ref_edge(input bit r, input bit e, input bit l, input int v);
      int nv;
      nv = (v == 0) ? 1 : v;
      if (r) begin
         period_len = DEFAULT_DIV; pos = 0; queued_len = 0; queued = 1'b0;
         m_tick = 1'b0; m_ack = 1'b0; m_sq = 1'b0;
      end else begin
         m_ack = l;
         m_tick = e && (pos == 0);
         if (e) m_sq = (pos < (period_len + 1) / 2);
         if (e) begin
            if (pos + 1 == period_len) begin
               pos = 0;
               if (l) begin period_len = nv; queued = 1'b0; end
               else if (queued) begin period_len = queued_len; queued = 1'b0; end
            end else begin
               pos = pos + 1;
               if (l) begin queued_len = nv; queued = 1'b1; end
            end
         end else begin
            if (queued) begin period_len = queued_len; pos = 0; end
            queued = l;
            if (l) queued_len = nv;
         end
      end
   endtask

   // One clock of stimulus: drive, let the edge happen, record expectation.
   task automatic step(input bit r, input bit e, input bit l, input int v);
      exp_t x;
      rst = r; en = e; div_load = l; div_val = WIDTH'(v);
      @(posedge clk);
      ref_edge(r, e, l, v);
      if (r) cyc = 0; else cyc = cyc + 1;
      x.cyc = cyc + 1; x.tick = m_tick; x.ack = m_ack; x.pend = queued;
      x.sq = SQ_ON ? m_sq : 1'b0;
      exp_q.push_back(x);
      #1;
   endtask

   task automatic run(input bit e, input int n);
      for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 0);
   endtask

   // Let the monitor consume everything issued so far (no extra edge).
   task automatic flush();
      @(negedge clk);
      #1;
   endtask

   // Advance with en=1 until the model sits at position p.
   task automatic goto_pos(input int p);
      int guard;
      guard = 0;
      while (pos != p && guard < 20000) begin
         step(1'b0, 1'b1, 1'b0, 0);
         guard++;
      end
      check("goto_pos_timeout", pos, p);
   endtask

   // Divisor set while idle: load, then one more idle cycle applies it.
   task automatic set_div(input int v);
      step(1'b0, 1'b0, 1'b1, v);
      step(1'b0, 1'b0, 1'b0, 0);
   endtask

   function automatic int last_gap();
      if (tick_log.size() < 2) return -1;
      return tick_log[tick_log.size()-1] - tick_log[tick_log.size()-2];
   endfunction

   // Monitor: compares every registered output once per cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t x;
         x = exp_q.pop_front();
         check("tick", tick, x.tick);
         check("div_ack", div_ack, x.ack);
         check("pending", pending, x.pend);
         check("sq_out", sq_out, x.sq);
         if (no_repeat) check("tick_repeat", tick && prev_tick, 0);
         prev_tick = tick;
         if (tick === 1'b1) tick_log.push_back(x.cyc);
         if (pending === 1'b1) pend_act++;
         if (x.pend) pend_exp++;
         if (div_ack === 1'b1) ack_act++;
         if (track_sq) sq_log.push_back(sq_out);
      end
   end

   initial begin
      int n5;
      bit pat5[5];
      bit pat4[4];
      pat5 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      pat4 = '{1'b1, 1'b1, 1'b0, 0};

      // Default run with the reset divisor.
      step(1'b1, 1'b0, 1'b1, 3);
      flush();
      check("reset_tick", tick, 0);
      check("reset_ack", div_ack, 0);
      check("reset_pending", pending, 0);
      check("reset_sq", sq_out, 0);
      tick_log.delete();
      no_repeat = 1'b1;
      run(1'b1, 30000);
      flush();
      no_repeat = 1'b0;
      check("default_tick_count", tick_log.size(), 3);
      if (tick_log.size() == 3) begin
         check("default_tick0", tick_log[0], 2);
         check("default_tick1", tick_log[1], 10002);
         check("default_tick2", tick_log[2], 20002);
      end

      // Mid-period load.
      step(1'b1, 1'b0, 1'b0, 0);
      set_div(10);
      tick_log.delete();
      run(1'b1, 25);
      goto_pos(3);
      flush();
      check("gap_before_load", last_gap(), 10);
      pend_act = 0; pend_exp = 0; ack_act = 0;
      step(1'b0, 1'b1, 1'b1, 4);
      run(1'b1, 30);
      flush();
      check("midload_ack", ack_act, 1);
      check("midload_pend_cycles", pend_act, pend_exp);
      check("gap_after_load", last_gap(), 4);

      // Load exactly on the wrap cycle.
      goto_pos(3);
      flush();
      pend_act = 0;
      step(1'b0, 1'b1, 1'b1, 6);
      run(1'b1, 20);
      flush();
      check("wrapload_pending", pend_act, 0);
      check("wrapload_gap", last_gap(), 6);

      // Back-to-back loads.
      goto_pos(1);
      flush();
      tick_log.delete();
      ack_act = 0;
      step(1'b0, 1'b1, 1'b1, 5);
      step(1'b0, 1'b1, 1'b1, 7);
      run(1'b1, 40);
      flush();
      check("b2b_acks", ack_act, 2);
      check("b2b_gap", last_gap(), 7);
      n5 = 0;
      for (int i = 1; i < tick_log.size(); i++)
         if (tick_log[i] - tick_log[i-1] == 5) n5++;
      check("b2b_no_gap5", n5, 0);

      // Edge divisors 0 and 1, idle hold.
      set_div(0);
      tick_log.delete();
      run(1'b1, 8);
      flush();
      check("div0_ticks", tick_log.size(), 8);
      run(1'b0, 4);
      set_div(1);
      tick_log.delete();
      run(1'b1, 8);
      run(1'b0, 3);
      flush();
      check("div1_ticks", tick_log.size(), 8);
      set_div(7);
      tick_log.delete();
      run(1'b1, 3);
      run(1'b0, 4);
      run(1'b1, 6);
      flush();
      check("idle_hold_gap", last_gap(), 11);

      // Reset mid-period with a divisor pending.
      run(1'b1, 2);
      step(1'b0, 1'b1, 1'b1, 3);
      step(1'b1, 1'b1, 1'b1, 9);
      flush();
      check("midrst_tick", tick, 0);
      check("midrst_ack", div_ack, 0);
      check("midrst_pending", pending, 0);
      check("midrst_sq", sq_out, 0);
      tick_log.delete();
      run(1'b1, 3);
      flush();
      check("post_rst_first_tick", tick_log.size() > 0 ? tick_log[0] : -1, 2);

      // Square output.
      set_div(5);
      flush();
      sq_log.delete();
      track_sq = 1'b1;
      run(1'b1, 15);
      flush();
      track_sq = 1'b0;
      for (int i = 0; i < 15; i++)
         if (i < sq_log.size()) check("sq_d5", sq_log[i], SQ_ON ? pat5[i % 5] : 1'b0);
      set_div(4);
      flush();
      sq_log.delete();
      track_sq = 1'b1;
      run(1'b1, 12);
      flush();
      track_sq = 1'b0;
      for (int i = 0; i < 12; i++)
         if (i < sq_log.size()) check("sq_d4", sq_log[i], SQ_ON ? pat4[i % 4] : 1'b0);

      // Randomized traffic against the model.
      step(1'b1, 1'b0, 1'b0, 0);
      set_div(3);
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 9) < 8),
              ($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 12)));
      end
      flush();
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
